// File: rtl/alu_seq.sv
// Registered valid/ready ALU with NZCV flags and held result.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [W-1:0] y_hi,
  output logic         c_out,
  output logic         v,
  output logic         n,
  output logic         z
);
  localparam int SHW = $clog2(W) + 1;
  localparam logic [SHW-1:0] SW = SHW'(W);

  localparam logic [3:0] OP_LLS = 4'd0;
  localparam logic [3:0] OP_LRS = 4'd1;
  localparam logic [3:0] OP_ALS = 4'd2;
  localparam logic [3:0] OP_ARS = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_ADD = 4'd8;
  localparam logic [3:0] OP_SUB = 4'd9;

  logic [SHW-1:0] s;
  logic [W:0]     lsh;
  logic [W:0]     rsh;
  logic [W:0]     ash;
  logic [W:0]     add_r;
  logic [W:0]     sub_r;
  logic           als_v;
  logic [W-1:0]   r_y;
  logic           r_c;
  logic           r_v;
  logic           accept;
  logic           is_mul;
  logic           load;
  logic           mul_done;
  logic [W-1:0]   mul_lo;
  logic [W-1:0]   mul_hi;
  logic [W-1:0]   n_y;
  logic [W-1:0]   n_hi;
  logic           n_c;
  logic           n_v;

  // Extra bit beside the operand catches the last bit shifted out.
  assign s     = b[SHW-1:0];
  assign lsh   = {1'b0, a} << s;
  assign rsh   = {a, 1'b0} >> s;
  assign ash   = $signed({a, 1'b0}) >>> s;
  assign add_r = {1'b0, a} + {1'b0, b}
               + {{W{1'b0}}, c_in};
  assign sub_r = {1'b0, a} - {1'b0, b}
               - {{W{1'b0}}, c_in};

  // Overflow iff shifting back does not recover a.
  assign als_v = (s >= SW) ? (a != '0)
    : (($signed(lsh[W-1:0]) >>> s)
       != $signed(a));

  always_comb begin
    r_y = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    case (opcode)
      OP_LLS: {r_c, r_y} = lsh;
      OP_ALS: begin
        {r_c, r_y} = lsh;
        r_v = als_v;
      end
      OP_LRS: {r_y, r_c} = rsh;
      OP_ARS: begin
        r_y = ash[W:1];
        r_c = (s > SW) ? 1'b0 : ash[0];
      end
      OP_NOT: r_y = ~a;
      OP_AND: r_y = a & b;
      OP_OR:  r_y = a | b;
      OP_XOR: r_y = a ^ b;
      OP_ADD: begin
        {r_c, r_y} = add_r;
        r_v = (a[W-1] == b[W-1])
           && (add_r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        {r_c, r_y} = sub_r;
        r_v = (a[W-1] != b[W-1])
           && (sub_r[W-1] != a[W-1]);
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   ma;
  logic [W-1:0]   mb;
  logic [W-1:0]   acc_hi;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic           last;

  assign is_mul = opcode == OP_MUL;
  assign last   = cnt == CW'(W - 1);
  assign sum    = {1'b0, acc_hi}
                + (mb[0] ? {1'b0, ma} : '0);
  // {acc_hi, mb} shifts right one step per edge.
  assign prod   = {sum, mb[W-1:1]};
  assign {mul_hi, mul_lo} = prod;
  assign mul_done = (state == MUL_RUN) && last;
  assign in_ready = (state == IDLE)
                 && (!out_valid || out_ready);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (accept && is_mul) state_d = MUL_RUN;
      MUL_RUN:
        if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      acc_hi <= '0;
    end else begin
      state <= state_d;
      if (accept && is_mul) begin
        ma     <= a;
        mb     <= b;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == MUL_RUN) begin
        acc_hi <= prod[2*W-1:W];
        mb     <= prod[W-1:0];
        cnt    <= cnt + CW'(1);
      end
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_lo   = '0;
  assign mul_hi   = '0;
  assign in_ready = !out_valid || out_ready;
`endif

  assign load = (accept && !is_mul) || mul_done;

  always_comb begin
    n_y  = r_y;
    n_hi = '0;
    n_c  = r_c;
    n_v  = r_v;
    if (mul_done) begin
      n_y  = mul_lo;
      n_hi = mul_hi;
      n_c  = 1'b0;
      n_v  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      c_out     <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      y         <= n_y;
      y_hi      <= n_hi;
      c_out     <= n_c;
      v         <= n_v;
      n         <= n_y[W-1];
      z         <= ~|n_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8), table vectors plus corner sequences.
// Honours ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [7:0] y_hi;
  logic       c_out;
  logic       v;
  logic       n;
  logic       z;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yh;
    logic       c;
    logic       v;
    logic       n;
    logic       z;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    exp_t       e;
  } vec_t;

  localparam int NV = 23;

  exp_t q[$];
  exp_t cur_exp;
  vec_t tv[NV];
  int   n_chk = 0;
  int   n_fail = 0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .c_out(c_out),
    .v(v), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(
    input logic [3:0] op, input logic [7:0] aa,
    input logic [7:0] bb, input logic ci,
    input logic [7:0] ey, input logic ec,
    input logic ev, input logic en, input logic ez);
    vec_t t;
    t.op = op; t.a = aa; t.b = bb; t.ci = ci;
    t.e = '{ey, 8'h00, ec, ev, en, ez};
    return t;
  endfunction

  function automatic exp_t model(
    input logic [3:0] op, input logic [7:0] aa,
    input logic [7:0] bb, input logic ci);
    exp_t e;
    int s, sa, sb, r;
    logic [15:0] p;
    e = '0;
    s = int'(bb[3:0]);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    case (op)
      4'd0, 4'd2: begin
        for (int i = 0; i < 8; i++)
          if (i >= s) e.y[i] = aa[i-s];
        if (s >= 1 && s <= 8) e.c = aa[8-s];
        if (op == 4'd2) begin
          for (int i = 1; i <= 8; i++)
            if (i <= s && aa[8-i] != aa[7]) e.v = 1'b1;
          if (s > 0 && e.y[7] != aa[7]) e.v = 1'b1;
        end
      end
      4'd1, 4'd3: begin
        for (int i = 0; i < 8; i++)
          if (i + s < 8) e.y[i] = aa[i+s];
          else if (op == 4'd3) e.y[i] = aa[7];
        if (s >= 1 && s <= 8) e.c = aa[s-1];
      end
      4'd4: e.y = ~aa;
      4'd5: e.y = aa & bb;
      4'd6: e.y = aa | bb;
      4'd7: e.y = aa ^ bb;
      4'd8: begin
        r = int'(aa) + int'(bb) + int'(ci);
        e.y = r[7:0];
        e.c = r > 255;
        r = sa + sb + int'(ci);
        e.v = r > 127 || r < -128;
      end
      4'd9: begin
        r = int'(aa) - int'(bb) - int'(ci);
        e.y = r[7:0];
        e.c = r < 0;
        r = sa - sb - int'(ci);
        e.v = r > 127 || r < -128;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd10: begin
        p = 16'(aa) * 16'(bb);
        e.y = p[7:0];
        e.yh = p[15:8];
      end
`endif
      default: ;
    endcase
    e.n = e.y[7];
    e.z = e.y == 8'h00;
    return e;
  endfunction

  task automatic chk(input string name,
    input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic step(output logic acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (acc) q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got y=%h expected none", y);
      end else begin
        e = q.pop_front();
        chk("sb_result",
            32'({y, y_hi, c_out, v, n, z}), 32'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op,
    input logic [7:0] aa, input logic [7:0] bb,
    input logic ci, input exp_t e, output int tries);
    logic acc;
    opcode = op; a = aa; b = bb; c_in = ci;
    cur_exp = e;
    in_valid = 1'b1;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      step(acc);
      tries++;
      if (!acc) out_ready = 1'b1;
    end
    if (!acc) chk("send_timeout", 32'(tries), 32'(0));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int k;
    out_ready = 1'b1;
    in_valid = 1'b0;
    k = 0;
    while (q.size() > 0 && k < 50) begin
      step(acc);
      k++;
    end
    chk("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int   t;
    int   total;
    int   cyc;
    logic acc;
    exp_t e;
    logic [3:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;

    tv[0]  = mkv(4'd8, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 1, 0);
    tv[1]  = mkv(4'd9, 8'h00, 8'h01, 0, 8'hFF, 1, 0, 1, 0);
    tv[2]  = mkv(4'd9, 8'h05, 8'h05, 0, 8'h00, 0, 0, 0, 1);
    tv[3]  = mkv(4'd3, 8'h90, 8'h09, 0, 8'hFF, 0, 0, 1, 0);
    tv[4]  = mkv(4'd1, 8'h81, 8'h01, 0, 8'h40, 1, 0, 0, 0);
    tv[5]  = mkv(4'd2, 8'h40, 8'h01, 0, 8'h80, 0, 1, 1, 0);
    tv[6]  = mkv(4'd0, 8'h81, 8'h01, 0, 8'h02, 1, 0, 0, 0);
    tv[7]  = mkv(4'd0, 8'h81, 8'h08, 0, 8'h00, 1, 0, 0, 1);
    tv[8]  = mkv(4'd3, 8'h81, 8'h01, 0, 8'hC0, 1, 0, 1, 0);
    tv[9]  = mkv(4'd4, 8'h0F, 8'h00, 0, 8'hF0, 0, 0, 1, 0);
    tv[10] = mkv(4'd5, 8'hF0, 8'h3C, 0, 8'h30, 0, 0, 0, 0);
    tv[11] = mkv(4'd6, 8'hF0, 8'h0C, 0, 8'hFC, 0, 0, 1, 0);
    tv[12] = mkv(4'd7, 8'hAA, 8'hAA, 0, 8'h00, 0, 0, 0, 1);
    tv[13] = mkv(4'd8, 8'hFF, 8'h00, 1, 8'h00, 1, 0, 0, 1);
    tv[14] = mkv(4'd8, 8'h80, 8'h80, 0, 8'h00, 1, 1, 0, 1);
    tv[15] = mkv(4'd9, 8'h80, 8'h01, 0, 8'h7F, 0, 1, 0, 0);
    tv[16] = mkv(4'd9, 8'h10, 8'h0F, 1, 8'h00, 0, 0, 0, 1);
    tv[17] = mkv(4'd12, 8'hFF, 8'hFF, 1, 8'h00, 0, 0, 0, 1);
    tv[18] = mkv(4'd1, 8'h80, 8'h10, 0, 8'h80, 0, 0, 1, 0);
    tv[19] = mkv(4'd3, 8'h80, 8'h08, 0, 8'hFF, 1, 0, 1, 0);
    tv[20] = mkv(4'd2, 8'hC0, 8'h01, 0, 8'h80, 1, 0, 1, 0);
    tv[21] = mkv(4'd0, 8'h01, 8'h09, 0, 8'h00, 0, 0, 0, 1);
    tv[22] = mkv(4'd3, 8'h7F, 8'h03, 0, 8'h0F, 1, 0, 0, 0);

    rst = 1'b1;
    in_valid = 1'b0;
    opcode = '0; a = '0; b = '0; c_in = 1'b0;
    out_ready = 1'b0;
    cur_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_outputs",
        32'({y, y_hi, c_out, v, n, z}), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));

    out_ready = 1'b1;
    total = 0;
    for (int i = 0; i < NV; i++) begin
      send(tv[i].op, tv[i].a, tv[i].b, tv[i].ci,
           tv[i].e, t);
      total += t;
      chk("latency1", 32'(out_valid), 32'(1));
    end
    chk("throughput", 32'(total), 32'(NV));
    drain();

    // Backpressure: XOR held, AND waits, then swaps in.
    out_ready = 1'b0;
    send(4'd7, 8'hF0, 8'h3C, 0,
         '{8'hCC, 8'h00, 0, 0, 1, 0}, t);
    opcode = 4'd5; a = 8'hF0; b = 8'h3C; c_in = 0;
    cur_exp = '{8'h30, 8'h00, 0, 0, 0, 0};
    in_valid = 1'b1;
    step(acc);
    chk("bp_no_accept", 32'(acc), 32'(0));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    chk("bp_held_y", 32'(y), 32'(8'hCC));
    out_ready = 1'b1;
    step(acc);
    in_valid = 1'b0;
    chk("bp_accept", 32'(acc), 32'(1));
    chk("bp_valid_kept", 32'(out_valid), 32'(1));
    drain();

`ifdef ALU_SEQ_MUL_EN
    send(4'd10, 8'hFF, 8'hFF, 0,
         '{8'h01, 8'hFE, 0, 0, 0, 0}, t);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk("mul_in_ready_low", 32'(in_ready), 32'(0));
      step(acc);
      cyc++;
    end
    chk("mul_latency", 32'(cyc), 32'(8));
    drain();

    send(4'd10, 8'h12, 8'h34, 0,
         model(4'd10, 8'h12, 8'h34, 0), t);
    repeat (3) step(acc);
    rst = 1'b1;
    step(acc);
    chk("mulrst_valid", 32'(out_valid), 32'(0));
    chk("mulrst_ready", 32'(in_ready), 32'(1));
    rst = 1'b0;
    q.delete();
    step(acc);
    chk("mulrst_idle", 32'(out_valid), 32'(0));
`else
    send(4'd10, 8'h03, 8'h04, 0,
         '{8'h00, 8'h00, 0, 0, 0, 1}, t);
    chk("op10_1cycle", 32'(out_valid), 32'(1));
    drain();
`endif

    // Reset discards a held result.
    out_ready = 1'b0;
    send(4'd8, 8'h01, 8'h02, 0,
         model(4'd8, 8'h01, 8'h02, 0), t);
    rst = 1'b1;
    step(acc);
    chk("heldrst_valid", 32'(out_valid), 32'(0));
    chk("heldrst_y", 32'(y), 32'(0));
    rst = 1'b0;
    q.delete();

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      e = model(rop, ra, rb, rc);
      send(rop, ra, rb, rc, e, t);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
